// File: rtl/ps2_frame_receiver.sv
// PS/2 frame receiver: shifts sampled data bits into a frame, checks start/parity/stop,
// and aborts a stalled partial frame after a watchdog timeout.
module ps2_frame_receiver #(
    parameter int DATA_BITS      = 8,
    parameter int PARITY_EN      = 1,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TIMER_W        = 17,
    parameter int CNT_W          = 8,
    localparam int FRAME_BITS    = DATA_BITS + PARITY_EN + 2,
    localparam int BC_W          = $clog2(FRAME_BITS + 1)
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic                 counter_reset,
    input  logic                 counter_en,
    input  logic                 ps2_data,
    output logic                 frame_valid,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 timeout,
    output logic                 busy,
    output logic [BC_W-1:0]      bit_count,
    output logic [CNT_W-1:0]     frame_count
);

    // Output interface: frame_valid and timeout are single-cycle pulses with no
    // backpressure; data_out and the error flags stay stable until the next frame_valid.

    localparam logic [BC_W-1:0]    LAST_BIT = BC_W'(FRAME_BITS - 1);
    localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [FRAME_BITS-2:0] r_sr;
    logic [BC_W-1:0]       r_bit_count;
    logic [TIMER_W-1:0]    r_timer;
    logic                  r_frame_valid;
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_parity_err;
    logic                  r_framing_err;
    logic                  r_timeout;
    logic [CNT_W-1:0]      r_frame_count;

    logic [FRAME_BITS-1:0] w_frame;
    logic                  w_last;
    logic                  w_par_err;
    logic                  w_frm_err;

    // The frame as it stands after this sample; the final bit comes straight from ps2_data.
    assign w_frame   = {ps2_data, r_sr};
    assign w_last    = (r_bit_count == LAST_BIT);
    assign w_par_err = (PARITY_EN != 0) && !(^w_frame[DATA_BITS+1:1]);
    assign w_frm_err = w_frame[0] | ~w_frame[FRAME_BITS-1];

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sr          <= '0;
            r_bit_count   <= '0;
            r_timer       <= '0;
            r_frame_valid <= 1'b0;
            r_data        <= '0;
            r_parity_err  <= 1'b0;
            r_framing_err <= 1'b0;
            r_timeout     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            r_timeout     <= 1'b0;
            if (counter_reset) begin
                r_sr        <= '0;
                r_bit_count <= '0;
                r_timer     <= '0;
            end else if (counter_en) begin
                r_sr    <= w_frame[FRAME_BITS-1:1];
                r_timer <= '0;
                if (w_last) begin
                    r_bit_count   <= '0;
                    r_frame_valid <= 1'b1;
                    r_data        <= w_frame[DATA_BITS:1];
                    r_parity_err  <= w_par_err;
                    r_framing_err <= w_frm_err;
                    r_frame_count <= r_frame_count + 1'b1;
                end else begin
                    r_bit_count <= r_bit_count + 1'b1;
                end
            end else if (r_bit_count != '0) begin
                // Watchdog only runs inside a partial frame.
                if (r_timer == TMO_LAST) begin
                    r_bit_count <= '0;
                    r_timer     <= '0;
                    r_timeout   <= 1'b1;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end else begin
                r_timer <= '0;
            end
        end
    end

    assign frame_valid = r_frame_valid;
    assign data_out    = r_data;
    assign parity_err  = r_parity_err;
    assign framing_err = r_framing_err;
    assign timeout     = r_timeout;
    assign busy        = (r_bit_count != '0);
    assign bit_count   = r_bit_count;
    assign frame_count = r_frame_count;

endmodule
